// File: rtl/mul4_share_arbiter.sv
// Shared 4x4 unsigned multiplier arbitrated among NUM_REQ requesters.
// Define ROUND_ROBIN_EN for rotating priority; fixed priority otherwise.
module mul4_array (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p + ({4'b0, a} << i);
    end
  end
endmodule

module mul4_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [7:0]           resp_product,
  output logic                 busy
);
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0] prod_q, prod_d;
  logic [7:0] mul_p;
  logic [ID_W-1:0] gid;
  logic any;
  logic [NUM_REQ-1:0] grant;
  logic [3:0] sel_a, sel_b;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic hi_any;
  logic [ID_W-1:0] hi_id;

  // Prefer the lowest valid index above the pointer, else wrap to lowest.
  always_comb begin
    any = 1'b0;
    gid = '0;
    hi_any = 1'b0;
    hi_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any = 1'b1;
        gid = ID_W'(i);
      end
      if (req_valid[i] && (i > int'(ptr_q))) begin
        hi_any = 1'b1;
        hi_id = ID_W'(i);
      end
    end
    if (hi_any) gid = hi_id;
  end
`else
  always_comb begin
    any = 1'b0;
    gid = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any = 1'b1;
        gid = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any && (gid == ID_W'(i))) begin
        grant[i] = 1'b1;
        sel_a = req_a[4*i +: 4];
        sel_b = req_b[4*i +: 4];
      end
    end
  end

  assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;

  mul4_array u_mul (
    .a(a_q),
    .b(b_q),
    .p(mul_p)
  );

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    id_d = id_q;
    prod_d = prod_q;
`ifdef ROUND_ROBIN_EN
    ptr_d = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_ready) begin
          a_d = sel_a;
          b_d = sel_b;
          id_d = gid;
`ifdef ROUND_ROBIN_EN
          ptr_d = gid;
`endif
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d = mul_p;
        state_d = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      prod_q <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
      prod_q <= prod_d;
`ifdef ROUND_ROBIN_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign resp_valid = (state_q == DONE);
  assign busy = (state_q != IDLE);
  assign resp_product = prod_q;
  assign resp_id = id_q;
endmodule

// File: tb/tb_mul4_share_arbiter.sv
// Directed bench for mul4_share_arbiter.
// Handles both ROUND_ROBIN_EN builds.
module tb_mul4_share_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0] req_ready;
  logic resp_valid;
  logic resp_ready;
  logic [1:0] resp_id;
  logic [7:0] resp_product;
  logic busy;

  int errors = 0;
  int checks = 0;

  mul4_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_product(resp_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic issue(input int i, input logic [3:0] a,
                       input logic [3:0] b, output logic [7:0] p,
                       output logic [1:0] id);
    int n;
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_valid[i] = 1'b1;
    #1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", 32'(n < 20), 1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    @(negedge clk);
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_wait", 32'(n < 20), 1);
    p = resp_product;
    id = resp_id;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] p;
    logic [1:0] id;
    int gcnt;
    int gid[5];
    int gcyc[5];
    int g;
    logic seen;
    logic got3;
    logic [7:0] p3;

    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_id", 32'(resp_id), 0);
    chk("rst_prod", 32'(resp_product), 0);
    chk("rst_busy", 32'(busy), 0);
    do_reset();

    // single request, cycle-exact
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd5;
    req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    chk("t1_mul_ready", 32'(req_ready), 0);
    chk("t1_mul_busy", 32'(busy), 1);
    chk("t1_mul_valid", 32'(resp_valid), 0);
    @(posedge clk);
    #1 chk("t1_valid", 32'(resp_valid), 1);
    chk("t1_prod", 32'(resp_product), 15);
    chk("t1_id", 32'(resp_id), 0);
    chk("t1_done_ready", 32'(req_ready), 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("t1_end_valid", 32'(resp_valid), 0);
    chk("t1_end_busy", 32'(busy), 0);
    @(negedge clk);

    // exhaustive operands on requester 2
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(2, 4'(a), 4'(b), p, id);
        chk("exh_prod", 32'(p), 32'(a * b));
        chk("exh_id", 32'(id), 2);
      end
    end

    // all requesters continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = 4'(i + 1);
      req_b[4*i +: 4] = 4'd2;
    end
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        chk("arb_onehot", 32'($countones(req_ready)), 1);
        g = 0;
        for (int j = 0; j < N; j++) if (req_ready[j]) g = j;
        gid[gcnt] = g;
        gcyc[gcnt] = c;
        gcnt++;
      end
      if (resp_valid)
        chk("arb_prod", 32'(resp_product), 32'((int'(resp_id) + 1) * 2));
      @(negedge clk);
    end
    chk("arb_count", 32'(gcnt), 5);
    for (int k = 0; k < 5 && k < gcnt; k++) begin
`ifdef ROUND_ROBIN_EN
      chk("arb_order", 32'(gid[k]), 32'(k % 4));
`else
      chk("arb_order", 32'(gid[k]), 0);
`endif
      if (k > 0) chk("arb_interval", 32'(gcyc[k] - gcyc[k-1]), 3);
    end

    // backpressure in DONE
    do_reset();
    req_a[7:4] = 4'd9;
    req_b[7:4] = 4'd11;
    req_valid = 4'b0010;
    #1 chk("bp_grant", 32'(req_ready), 4'b0010);
    @(posedge clk);
    #1 req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_prod", 32'(resp_product), 99);
      chk("bp_id", 32'(resp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("bp_release", 32'(resp_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 4'b0001);
    req_valid = '0;
    @(negedge clk);

    // reset during MUL
    req_a[15:12] = 4'd2;
    req_b[15:12] = 4'd3;
    req_valid = 4'b1000;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("rm_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_busy0", 32'(busy), 0);
    chk("rm_valid0", 32'(resp_valid), 0);
    chk("rm_prod0", 32'(resp_product), 0);
    chk("rm_id0", 32'(resp_id), 0);
    chk("rm_ready0", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("rm_no_resp", 32'(seen), 0);
    issue(0, 4'd7, 4'd9, p, id);
    chk("rm_next_prod", 32'(p), 63);
    chk("rm_next_id", 32'(id), 0);

    // withdrawn request
    req_a[3:0] = 4'd1;
    req_b[3:0] = 4'd1;
    req_a[7:4] = 4'd4;
    req_b[7:4] = 4'd4;
    req_a[15:12] = 4'd5;
    req_b[15:12] = 4'd6;
    req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = 4'b1010;
    @(negedge clk);
    chk("wd_mul_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("wd_done_valid", 32'(resp_valid), 1);
    chk("wd_done_id", 32'(resp_id), 0);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("wd_grant3", 32'(req_ready), 4'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    resp_ready = 1'b1;
    seen = 1'b0;
    got3 = 1'b0;
    p3 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid && resp_id == 2'd1) seen = 1'b1;
      if (resp_valid && resp_id == 2'd3) begin
        got3 = 1'b1;
        p3 = resp_product;
      end
    end
    resp_ready = 1'b0;
    chk("wd_no_id1", 32'(seen), 0);
    chk("wd_got3", 32'(got3), 1);
    chk("wd_prod3", 32'(p3), 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
